// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle control FSM
// Purpose: state codes, opcode constants, ALUOp/PCSource/ALUSrcB codes,
//          the packed control bundle and an opcode legality helper.
// Ports:   none (package).
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXE    = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXE    = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       irWrite;
        logic       aluSrcA;
        logic       regWrite;
        logic       regDst;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
        logic       illegal;
        logic [3:0] state;
    } ctrl_t;

    function automatic logic isLegalOp(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - datapath-facing signal bundle of the control FSM
// Purpose: groups opcode/mem_ready inputs and all datapath control outputs.
// Ports:   master = datapath side (drives opcode, mem_ready),
//          slave  = controller side (drives controls, illegal, state).
interface mc_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic       illegal;
    logic [3:0] state;

    modport master (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
               ALUSrcB, illegal, state
    );

    modport slave (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
               ALUSrcB, illegal, state
    );
endinterface

// File: rtl/mc_control_decode.sv
// rtl/mc_control_decode.sv - combinational state-to-control decoder
// Purpose: maps the current state (plus memReady in FETCH and opcode in
//          DECODE) to the datapath control bundle; everything is forced
//          to zero while rst is high.
// Ports:   rst, stateQ[3:0], memReady, opcode[5:0] in; ctrl (ctrl_t) out.
module mc_control_decode
    import mc_pkg::*;
(
    input  logic       rst,
    input  logic [3:0] stateQ,
    input  logic       memReady,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            ctrl.state = stateQ;
            case (stateQ)
                S_FETCH: begin
                    ctrl.memRead  = 1'b1;
                    ctrl.aluSrcB  = SRCB_FOUR;
                    ctrl.aluOp    = ALU_ADD;
                    ctrl.pcSource = PC_ALU;
                    // IR and PC only update once the fetch actually completes
                    ctrl.irWrite  = memReady;
                    ctrl.pcWrite  = memReady;
                end
                S_DECODE: begin
                    ctrl.aluSrcB = SRCB_IMM_SH2;
                    ctrl.aluOp   = ALU_ADD;
                    ctrl.illegal = !isLegalOp(opcode);
                end
                S_MEM_ADDR, S_I_EXE: begin
                    ctrl.aluSrcA = 1'b1;
                    ctrl.aluSrcB = SRCB_IMM;
                    ctrl.aluOp   = ALU_ADD;
                end
                S_MEM_RD: begin
                    ctrl.memRead = 1'b1;
                    ctrl.iorD    = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.regWrite = 1'b1;
                    ctrl.memtoReg = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.memWrite = 1'b1;
                    ctrl.iorD     = 1'b1;
                end
                S_R_EXE: begin
                    ctrl.aluSrcA = 1'b1;
                    ctrl.aluSrcB = SRCB_REG;
                    ctrl.aluOp   = ALU_FUNCT;
                end
                S_R_WB: begin
                    ctrl.regWrite = 1'b1;
                    ctrl.regDst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.aluSrcA     = 1'b1;
                    ctrl.aluSrcB     = SRCB_REG;
                    ctrl.aluOp       = ALU_SUB;
                    ctrl.pcWriteCond = 1'b1;
                    ctrl.pcSource    = PC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pcWrite  = 1'b1;
                    ctrl.pcSource = PC_JUMP;
                end
                S_I_WB: begin
                    ctrl.regWrite = 1'b1;
                end
                // codes 12-15 are unreachable in normal operation; flag them
                default: ctrl.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle processor main control FSM (Moore)
// Purpose: sequences FETCH/DECODE/execute/writeback states per opcode and
//          drives the datapath controls through mc_control_decode.
// Ports:   clk, rst (sync, active-high); bus (mc_control_if.slave) carries
//          opcode, mem_ready, datapath controls, illegal and debug state.
module mc_control
    import mc_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mc_control_if.slave   bus
);

    state_t stateQ;
    state_t stateD;
    logic   memReady;
    ctrl_t  ctrl;

    // with waiting disabled every memory access is treated as single-cycle
    assign memReady = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= S_FETCH;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = S_FETCH;
        case (stateQ)
            S_FETCH:    stateD = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: stateD = S_MEM_ADDR;
                    OP_R:         stateD = S_R_EXE;
                    OP_BEQ:       stateD = S_BRANCH;
                    OP_J:         stateD = S_JUMP;
                    OP_ADDI:      stateD = S_I_EXE;
                    default:      stateD = S_FETCH;
                endcase
            end
            S_MEM_ADDR: stateD = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   stateD = memReady ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   stateD = memReady ? S_FETCH : S_MEM_WR;
            S_R_EXE:    stateD = S_R_WB;
            S_I_EXE:    stateD = S_I_WB;
            default:    stateD = S_FETCH;
        endcase
    end

    mc_control_decode u_decode (
        .rst      (rst),
        .stateQ   (stateQ),
        .memReady (memReady),
        .opcode   (bus.opcode),
        .ctrl     (ctrl)
    );

    assign bus.PCWrite     = ctrl.pcWrite;
    assign bus.PCWriteCond = ctrl.pcWriteCond;
    assign bus.IorD        = ctrl.iorD;
    assign bus.MemRead     = ctrl.memRead;
    assign bus.MemWrite    = ctrl.memWrite;
    assign bus.MemtoReg    = ctrl.memtoReg;
    assign bus.IRWrite     = ctrl.irWrite;
    assign bus.ALUSrcA     = ctrl.aluSrcA;
    assign bus.RegWrite    = ctrl.regWrite;
    assign bus.RegDst      = ctrl.regDst;
    assign bus.PCSource    = ctrl.pcSource;
    assign bus.ALUOp       = ctrl.aluOp;
    assign bus.ALUSrcB     = ctrl.aluSrcB;
    assign bus.illegal     = ctrl.illegal;
    assign bus.state       = ctrl.state;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - self-checking bench for mc_control
module tb_mc_control;

    logic clk;
    logic rst;
    int   nCmp = 0;
    int   nErr = 0;

    mc_control_if ifc ();

    mc_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] obsVec;
    assign obsVec = {ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead,
                     ifc.MemWrite, ifc.MemtoReg, ifc.IRWrite, ifc.ALUSrcA,
                     ifc.RegWrite, ifc.RegDst, ifc.PCSource, ifc.ALUOp,
                     ifc.ALUSrcB, ifc.illegal};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected control vector, written straight from the per-state table.
    function automatic logic [16:0] expOut(input int st, input bit rdy, input bit r, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srcA, rw, rdst, ill;
        logic [1:0] pcs, aop, srcB;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, srcA, rw, rdst, ill} = '0;
        {pcs, aop, srcB} = '0;
        if (!r) begin
            case (st)
                0:  begin mrd = 1; irw = rdy; pcw = rdy; srcB = 2'b01; end
                1:  begin srcB = 2'b11;
                          ill = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                             6'b000100, 6'b000010, 6'b001000}); end
                2:  begin srcA = 1; srcB = 2'b10; end
                3:  begin mrd = 1; iord = 1; end
                4:  begin rw = 1; m2r = 1; end
                5:  begin mwr = 1; iord = 1; end
                6:  begin srcA = 1; aop = 2'b10; end
                7:  begin rw = 1; rdst = 1; end
                8:  begin srcA = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
                9:  begin pcw = 1; pcs = 2'b10; end
                10: begin srcA = 1; srcB = 2'b10; end
                11: begin rw = 1; end
                default: ill = 1;
            endcase
        end
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srcA, rw, rdst, pcs, aop, srcB, ill};
    endfunction

    // State walk of one instruction as a list of visited states.
    function automatic void buildPath(input logic [5:0] op, output int path[$]);
        path = {};
        case (op)
            6'b100011: path = {0, 1, 2, 3, 4};
            6'b101011: path = {0, 1, 2, 5};
            6'b000000: path = {0, 1, 6, 7};
            6'b001000: path = {0, 1, 10, 11};
            6'b000100: path = {0, 1, 8};
            6'b000010: path = {0, 1, 9};
            default:   path = {0, 1};
        endcase
    endfunction

    // Runs one instruction from FETCH; states 0/3/5 wait on mem_ready.
    task automatic runInstr(input logic [5:0] op, input int stallPct, input int memStalls,
                            output int cycles, output int memWr, output int regWr, output int ill);
        int  path[$];
        int  idx = 0;
        int  guard = 0;
        int  stallLeft = memStalls;
        int  st;
        bit  rdy;
        buildPath(op, path);
        cycles = 0; memWr = 0; regWr = 0; ill = 0;
        ifc.opcode = op;
        while (idx < path.size() && guard < 300) begin
            st = path[idx];
            if (st == 3 || st == 5) begin
                rdy = (stallLeft == 0);
                if (stallLeft > 0) stallLeft--;
            end else begin
                rdy = ($urandom_range(99) >= stallPct);
            end
            ifc.mem_ready = rdy;
            #2;
            check("state", 32'(ifc.state), 32'(st));
            check("outputs", 32'(obsVec), 32'(expOut(st, rdy, 1'b0, op)));
            check("rd_wr_excl", 32'(ifc.MemRead & ifc.MemWrite), 32'd0);
            cycles++;
            memWr += int'(ifc.MemWrite);
            regWr += int'(ifc.RegWrite);
            ill   += int'(ifc.illegal);
            @(posedge clk);
            #1;
            if (!((st == 0 || st == 3 || st == 5) && !rdy)) idx++;
            guard++;
        end
        check("cycle_budget", 32'(guard < 300), 32'd1);
    endtask

    initial begin
        int cyc, mw, rw, il;
        logic [5:0] legal [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        logic [5:0] op;

        rst = 1'b1;
        ifc.opcode = 6'b100011;
        ifc.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            #2;
            check("reset_outputs", 32'(obsVec), 32'd0);
            check("reset_state", 32'(ifc.state), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check("first_state", 32'(ifc.state), 32'd0);
        check("first_memread", 32'(ifc.MemRead), 32'd1);

        runInstr(6'b100011, 0, 0, cyc, mw, rw, il);
        check("lw_latency", 32'(cyc), 32'd5);
        check("lw_regwrite", 32'(rw), 32'd1);

        runInstr(6'b101011, 0, 3, cyc, mw, rw, il);
        check("sw_memwrite_cycles", 32'(mw), 32'd4);
        check("sw_regwrite", 32'(rw), 32'd0);
        check("sw_cycles", 32'(cyc), 32'd7);

        runInstr(6'b101011, 0, 0, cyc, mw, rw, il);
        check("sw_latency", 32'(cyc), 32'd4);
        runInstr(6'b000000, 0, 0, cyc, mw, rw, il);
        check("r_latency", 32'(cyc), 32'd4);
        runInstr(6'b001000, 0, 0, cyc, mw, rw, il);
        check("addi_latency", 32'(cyc), 32'd4);
        runInstr(6'b000100, 0, 0, cyc, mw, rw, il);
        check("beq_latency", 32'(cyc), 32'd3);
        runInstr(6'b000010, 0, 0, cyc, mw, rw, il);
        check("j_latency", 32'(cyc), 32'd3);

        runInstr(6'b111111, 0, 0, cyc, mw, rw, il);
        check("illegal_pulse", 32'(il), 32'd1);
        check("illegal_cycles", 32'(cyc), 32'd2);
        check("illegal_no_write", 32'(rw + mw), 32'd0);

        // abort an LW while it waits in MEM_RD
        ifc.opcode = 6'b100011;
        ifc.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        ifc.mem_ready = 1'b0;
        #2;
        check("abort_in_memrd", 32'(ifc.state), 32'd3);
        rst = 1'b1;
        #1;
        check("abort_outputs", 32'(obsVec), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_state", 32'(ifc.state), 32'd0);
        check("abort_no_regwrite", 32'(ifc.RegWrite), 32'd0);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : legal[$urandom_range(5)];
            runInstr(op, 30, $urandom_range(3), cyc, mw, rw, il);
            check("rand_illegal_count", 32'(il), 32'(!(op inside {legal})));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
